adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
Synthesizable self-checking monitor on the receiving end of the adder datapath interface. It takes the same operand stream that feeds `adder` (inA/inB) and computes the expected {sum, isOdd}. It delays that expectation by the adder's pipeline latency, then compares it against the adder's `out`/`isOdd`. It keeps pass/fail counts and a sticky capture of the first mismatch, so datapath labs self-check in simulation and on the board.

Parameters:
W, 32, operand width; sum width is W+1.
LAT, 1, adder latency in cycles from operand sample to valid result; legal range 1..8.
CNT_W, 16, width of pass/fail/index counters.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a run from IDLE or DONE, clears counters/capture.
stop  input  1  one-cycle pulse; ends operand acceptance, triggers drain.
in_valid  input  1  operands on inA/inB are presented to the adder this cycle.
inA  input  W  operand A, same value driven to adder.inA.
inB  input  W  operand B, same value driven to adder.inB.
dut_out  input  W+1  adder.out.
dut_is_odd  input  1  adder.isOdd.
busy  output  1  high in RUN or DRAIN.
done  output  1  high in DONE.
pass_cnt  output  CNT_W  number of matching comparisons.
fail_cnt  output  CNT_W  number of mismatching comparisons.
err  output  1  sticky; set on first mismatch.
first_fail_idx  output  CNT_W  sample index (0-based, run-relative) of first mismatch.
first_fail_exp  output  W+1  expected sum at first mismatch.
first_fail_got  output  W+1  dut_out at first mismatch.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all outputs 0, delay-line valid bits cleared, sample index 0. rst overrides every other input and applies mid-run.
- Expected value: exp = {1'b0,inA} + {1'b0,inB}, full W+1 bits, with no truncation. Expected odd = exp[0].
- Delay line: LAT stages of {valid, exp, idx}. Stage 0 loads on each edge with valid = in_valid && state==RUN. Stages shift every cycle unconditionally.
- Comparison occurs in the cycle the last stage is valid. Match requires dut_out==exp and dut_is_odd==exp[0]. Counter/capture update is registered, one cycle after the compare cycle.
- Match increments pass_cnt; mismatch increments fail_cnt. Both counters saturate at 2^CNT_W-1 and do not wrap.
- First mismatch while err=0: set err and load first_fail_idx/exp/got. Later mismatches leave the capture unchanged.
- Sample index increments per accepted operand. It wraps modulo 2^CNT_W; wrap is harmless because the index is only a tag.
- FSM:
  - IDLE: start -> RUN, clearing counters, err, capture and index.
  - RUN: stop -> DRAIN; operands accepted only in RUN. start in RUN is ignored.
  - DRAIN: in_valid ignored. When all delay-line valid bits are 0 -> DONE. Comparisons still complete in DRAIN.
  - DONE: outputs hold. start -> RUN, with the same clears as from IDLE.
- Simultaneous start and stop: start wins in IDLE/DONE; stop wins in RUN.
- stop and in_valid in the same RUN cycle: that operand is accepted, and is the last one.
- busy = state in {RUN, DRAIN}; done = state==DONE.
- dut_out/dut_is_odd are ignored whenever the last delay stage is invalid.

Test Plan:
1. LAT=1; rst 2 cycles, start, then operand pairs (0,0),(1,1),(5,6),(2,2),(3,3),(1,8),(1,2),(3,4) on consecutive negedges, correct model adder, stop -> DONE reached LAT+1 cycles after drain; pass_cnt=8, fail_cnt=0, err=0.
2. Overflow: W=32, inA=32'hFFFFFFFF, inB=1, dut_out=33'h1_00000000, dut_is_odd=0 -> pass. Same operands with dut_out=0 -> fail_cnt=1, first_fail_exp=33'h1_00000000, first_fail_got=0.
3. Fault injection: the third sample (5,6) returns dut_is_odd=0 with out=11 -> err=1, first_fail_idx=2, first_fail_exp=11. A later injected fault on idx 5 increments fail_cnt to 2 and leaves the capture unchanged.
4. LAT=3, in_valid gapped (1,0,1,1), then stop -> busy stays high 3 cycles in DRAIN; pass_cnt=3; bogus dut_out during invalid slots is not counted.
5. rst asserted mid-RUN with 2 samples in flight -> next cycle state=IDLE, counters 0, in-flight samples never compared.
6. CNT_W=2, 5 matching samples -> pass_cnt saturates at 3. A second run via start from DONE clears to 0.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker: predicts {sum, isOdd} from the adder operands, delays it by LAT and scores the adder output
module adder_result_checker #(
  parameter int W = 32,
  parameter int LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic [W:0]       dut_out,
  input  logic             dut_is_odd,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [W:0]       first_fail_exp,
  output logic [W:0]       first_fail_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LAT-1:0] vld_q;
  logic [W:0] sum_q [LAT];
  logic [CNT_W-1:0] tag_q [LAT];
  logic [CNT_W-1:0] idx_q, pass_q, fail_q, ffi_q;
  logic [W:0] ffe_q, ffg_q;
  logic err_q, accept, clr, cmp, match;
  assign accept = in_valid && state_q == RUN;
  assign clr = start && (state_q == IDLE || state_q == DONE);
  assign cmp = vld_q[LAT-1];
  assign match = dut_out == sum_q[LAT-1] && dut_is_odd == sum_q[LAT-1][0];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? RUN : IDLE;
      RUN:   state_d = stop ? DRAIN : RUN;
      DRAIN: state_d = ~|vld_q ? DONE : DRAIN;
      DONE:  state_d = start ? RUN : DONE;
      default: state_d = IDLE;
    endcase
  end
  // data stages carry no reset; only the valid bits decide whether a stage is compared
  always_ff @(posedge clk) begin
    sum_q[0] <= {1'b0, inA} + {1'b0, inB};
    tag_q[0] <= idx_q;
    for (int i = 1; i < LAT; i++) begin
      sum_q[i] <= sum_q[i-1];
      tag_q[i] <= tag_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q <= '0;
      idx_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      err_q <= 1'b0;
      ffi_q <= '0;
      ffe_q <= '0;
      ffg_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= LAT'({vld_q, accept});
      if (clr) begin
        idx_q <= '0;
        pass_q <= '0;
        fail_q <= '0;
        err_q <= 1'b0;
        ffi_q <= '0;
        ffe_q <= '0;
        ffg_q <= '0;
      end else begin
        if (accept) idx_q <= idx_q + CNT_W'(1);
        if (cmp && match && pass_q != '1) pass_q <= pass_q + CNT_W'(1);
        if (cmp && !match && fail_q != '1) fail_q <= fail_q + CNT_W'(1);
        if (cmp && !match && !err_q) begin
          err_q <= 1'b1;
          ffi_q <= tag_q[LAT-1];
          ffe_q <= sum_q[LAT-1];
          ffg_q <= dut_out;
        end
      end
    end
  end
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_exp = ffe_q;
  assign first_fail_got = ffg_q;
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: model adder with fault injection feeds three checker variants; run summaries are scoreboarded
module tb_adder_result_checker;
  logic clk = 0, rst = 1, start = 0, stop = 0, in_valid = 0;
  logic [31:0] inA = 0, inB = 0;
  int flt = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  // model adder pipeline: tap 0 is LAT=1, tap 2 is LAT=3; invalid slots carry random junk
  logic [2:0] p_v = 0;
  logic [32:0] p_s [3];
  int p_f [3];
  logic [32:0] junk = 0;
  always @(posedge clk) begin
    p_v <= {p_v[1:0], in_valid};
    p_s[0] <= {1'b0, inA} + {1'b0, inB};
    p_f[0] <= flt;
    for (int i = 1; i < 3; i++) begin
      p_s[i] <= p_s[i-1];
      p_f[i] <= p_f[i-1];
    end
    junk <= 33'({$urandom(), $urandom()});
  end
  logic [32:0] out1, out3;
  logic odd1, odd3;
  assign out1 = p_v[0] ? (p_f[0] == 2 ? 33'd0 : p_s[0]) : junk;
  assign odd1 = p_v[0] ? p_s[0][0] ^ (p_f[0] == 1) : junk[1];
  assign out3 = p_v[2] ? (p_f[2] == 2 ? 33'd0 : p_s[2]) : junk;
  assign odd3 = p_v[2] ? p_s[2][0] ^ (p_f[2] == 1) : junk[1];
  logic busy1, done1, err1, busy2, done2, err2, busy3, done3, err3;
  logic [15:0] pc1, fc1, fi1, pc3, fc3, fi3;
  logic [1:0] pc2, fc2, fi2;
  logic [32:0] fe1, fg1, fe2, fg2, fe3, fg3;
  adder_result_checker #(.W(32), .LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .inA(inA), .inB(inB),
    .dut_out(out1), .dut_is_odd(odd1), .busy(busy1), .done(done1), .pass_cnt(pc1), .fail_cnt(fc1),
    .err(err1), .first_fail_idx(fi1), .first_fail_exp(fe1), .first_fail_got(fg1));
  adder_result_checker #(.W(32), .LAT(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .inA(inA), .inB(inB),
    .dut_out(out1), .dut_is_odd(odd1), .busy(busy2), .done(done2), .pass_cnt(pc2), .fail_cnt(fc2),
    .err(err2), .first_fail_idx(fi2), .first_fail_exp(fe2), .first_fail_got(fg2));
  adder_result_checker #(.W(32), .LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .inA(inA), .inB(inB),
    .dut_out(out3), .dut_is_odd(odd3), .busy(busy3), .done(done3), .pass_cnt(pc3), .fail_cnt(fc3),
    .err(err3), .first_fail_idx(fi3), .first_fail_exp(fe3), .first_fail_got(fg3));
  typedef struct {int pass; int fail; int err; int idx; int dr; logic [32:0] ex; logic [32:0] got;} exp_t;
  exp_t q1[$], q2[$], q3[$];
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, x);
    end
  endtask
  task automatic cmp_run(input string nm, input exp_t e, input int pa, input int fa, input int er,
                         input int ix, input int dr, input logic [32:0] ex, input logic [32:0] got);
    chk({nm, ".pass"}, pa, e.pass);
    chk({nm, ".fail"}, fa, e.fail);
    chk({nm, ".err"}, er, e.err);
    chk({nm, ".idx"}, ix, e.idx);
    chk({nm, ".exp"}, ex, e.ex);
    chk({nm, ".got"}, got, e.got);
    chk({nm, ".drain"}, dr, e.dr);
  endtask
  task automatic no_exp(input string nm);
    total++;
    bad++;
    $display("FAIL %s done rose with no expected run queued", nm);
  endtask
  // sl=1 when stop coincides with the last operand, which costs one extra drain cycle
  task automatic push(input int pa, input int fa, input int er, input int ix,
                      input logic [32:0] ex, input logic [32:0] got, input int sl);
    exp_t e;
    e = '{pa, fa, er, ix, 1 + sl, ex, got};
    q1.push_back(e);
    e.dr = 3 + sl;
    q3.push_back(e);
    e = '{pa > 3 ? 3 : pa, fa > 3 ? 3 : fa, er, ix % 4, 1 + sl, ex, got};
    q2.push_back(e);
  endtask
  logic stop_seen = 0;
  logic [2:0] dprev = 0;
  int dr1 = 0, dr2 = 0, dr3 = 0;
  always @(posedge clk) stop_seen <= (rst || start) ? 1'b0 : (stop ? 1'b1 : stop_seen);
  always @(negedge clk) begin
    dprev <= {done3, done2, done1};
    dr1 <= !stop_seen ? 0 : dr1 + int'(busy1);
    dr2 <= !stop_seen ? 0 : dr2 + int'(busy2);
    dr3 <= !stop_seen ? 0 : dr3 + int'(busy3);
    if (done1 && !dprev[0]) begin
      if (q1.size() == 0) no_exp("u1");
      else cmp_run("u1", q1.pop_front(), pc1, fc1, err1, fi1, dr1, fe1, fg1);
    end
    if (done2 && !dprev[1]) begin
      if (q2.size() == 0) no_exp("u2");
      else cmp_run("u2", q2.pop_front(), pc2, fc2, err2, fi2, dr2, fe2, fg2);
    end
    if (done3 && !dprev[2]) begin
      if (q3.size() == 0) no_exp("u3");
      else cmp_run("u3", q3.pop_front(), pc3, fc3, err3, fi3, dr3, fe3, fg3);
    end
  end
  task automatic go();
    @(negedge clk);
    start = 1; stop = 0; in_valid = 0; flt = 0;
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int f, input bit stp);
    @(negedge clk);
    start = 0; in_valid = 1; inA = a; inB = b; flt = f; stop = stp;
  endtask
  task automatic idle(input bit stp);
    @(negedge clk);
    start = 0; in_valid = 0; flt = 0; stop = stp;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!(done1 && done2 && done3) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL %s timeout done=%b%b%b exp=111", nm, done1, done2, done3);
    end
    @(negedge clk);
  endtask
  task automatic zero_chk(input string nm);
    chk({nm, ".u1"}, {busy1, done1, err1, |fe1, |fg1, pc1, fc1, fi1}, 0);
    chk({nm, ".u2"}, {busy2, done2, err2, |fe2, |fg2, pc2, fc2, fi2}, 0);
    chk({nm, ".u3"}, {busy3, done3, err3, |fe3, |fg3, pc3, fc3, fi3}, 0);
  endtask
  logic [31:0] va [8] = '{0, 1, 5, 2, 3, 1, 1, 3};
  logic [31:0] vb [8] = '{0, 1, 6, 2, 3, 8, 2, 4};
  initial begin
    repeat (2) @(negedge clk);
    zero_chk("reset");
    rst = 0;
    push(8, 0, 0, 0, 33'd0, 33'd0, 1);
    go();
    for (int i = 0; i < 8; i++) op(va[i], vb[i], 0, i == 7);
    idle(0);
    wait_done("run1");
    push(1, 1, 1, 1, 33'h1_0000_0000, 33'd0, 1);
    go();
    op(32'hFFFF_FFFF, 32'd1, 0, 0);
    op(32'hFFFF_FFFF, 32'd1, 2, 1);
    idle(0);
    wait_done("overflow");
    push(6, 2, 1, 2, 33'd11, 33'd11, 1);
    go();
    for (int i = 0; i < 8; i++) op(va[i], vb[i], i == 2 ? 1 : (i == 5 ? 2 : 0), i == 7);
    idle(0);
    wait_done("faults");
    push(3, 0, 0, 0, 33'd0, 33'd0, 0);
    go();
    op(2, 3, 0, 0);
    idle(0);
    op(4, 4, 0, 0);
    op(7, 0, 0, 0);
    idle(1);
    idle(0);
    wait_done("gapped");
    go();
    op(1, 1, 0, 0);
    op(2, 2, 0, 0);
    @(negedge clk);
    in_valid = 0; start = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    zero_chk("midrst");
    repeat (6) @(negedge clk);
    zero_chk("postrst");
    chk("queues_left", q1.size() + q2.size() + q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
